// File: rtl/axi_rr_arb.sv
// Packet-granular round-robin arbiter: NM valid/ready sources share one
// forward-registered downstream channel; the source index rides along as s_id.
module axi_rr_arb #(
    parameter int NM = 4,
    parameter int DW = 64,
    parameter int IW = $clog2(NM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM*DW-1:0] m_data,
    input  logic [NM-1:0]    m_valid,
    input  logic [NM-1:0]    m_last,
    output logic [NM-1:0]    m_ready,
    output logic [DW-1:0]    s_data,
    output logic             s_valid,
    output logic             s_last,
    output logic [IW-1:0]    s_id,
    input  logic             s_ready
);

    typedef enum logic {
        IDLE,
        LOCK
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          s_valid_q, s_valid_d;
    logic [DW-1:0] s_data_q, s_data_d;
    logic          s_last_q, s_last_d;
    logic [IW-1:0] s_id_q, s_id_d;

    logic          win_found;
    logic [IW-1:0] winner;
    logic [IW-1:0] sel;
    logic [IW-1:0] sel_inc;
    logic          sel_valid;
    logic          slot_free;
    logic          accept;
    logic [DW-1:0] sel_data;

    // Rotating priority search starting at ptr; the wrap is done by subtraction
    // so non-power-of-2 NM works without a modulo.
    always_comb begin
        int unsigned idx;
        winner    = '0;
        win_found = 1'b0;
        for (int unsigned k = 0; k < NM; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NM) idx = idx - NM;
            if (!win_found && m_valid[IW'(idx)]) begin
                win_found = 1'b1;
                winner    = IW'(idx);
            end
        end
    end

    always_comb begin
        sel       = (state_q == LOCK) ? gnt_q : winner;
        sel_valid = (state_q == LOCK) ? 1'b1 : win_found;
        sel_inc   = (32'(sel) == NM - 1) ? '0 : sel + 1'b1;
        slot_free = ~s_valid_q | s_ready;

        m_ready = '0;
        if (!rst && sel_valid) m_ready[sel] = slot_free;
        accept = m_valid[sel] & m_ready[sel];

        sel_data = '0;
        for (int unsigned k = 0; k < NM; k++) begin
            if (IW'(k) == sel) sel_data = m_data[k*DW +: DW];
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_last_d  = s_last_q;
        s_id_d    = s_id_q;

        if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = sel_data;
            s_last_d  = m_last[sel];
            s_id_d    = sel;
            if (m_last[sel]) begin
                state_d = IDLE;
                ptr_d   = sel_inc;
            end else begin
                state_d = LOCK;
                gnt_d   = sel;
            end
        end else if (s_ready) begin
            s_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_last_q  <= 1'b0;
            s_id_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            s_last_q  <= s_last_d;
            s_id_q    <= s_id_d;
        end
    end

    assign s_valid = s_valid_q;
    assign s_data  = s_data_q;
    assign s_last  = s_last_q;
    assign s_id    = s_id_q;

endmodule

// File: tb/tb_axi_rr_arb.sv
// Bench for axi_rr_arb: directed sequences on a 4-requester instance and a
// randomized soak with a per-source scoreboard on a 3-requester instance.
module tb_axi_rr_arb;

    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [4*DW-1:0] a_m_data;
    logic [3:0]      a_m_valid, a_m_last, a_m_ready;
    logic [DW-1:0]   a_s_data;
    logic            a_s_valid, a_s_last, a_s_ready;
    logic [1:0]      a_s_id;

    logic [3*DW-1:0] b_m_data;
    logic [2:0]      b_m_valid, b_m_last, b_m_ready;
    logic [DW-1:0]   b_s_data;
    logic            b_s_valid, b_s_last, b_s_ready;
    logic [1:0]      b_s_id;

    axi_rr_arb #(.NM(4), .DW(DW)) u_dut_a (
        .clk(clk), .rst(rst),
        .m_data(a_m_data), .m_valid(a_m_valid), .m_last(a_m_last), .m_ready(a_m_ready),
        .s_data(a_s_data), .s_valid(a_s_valid), .s_last(a_s_last), .s_id(a_s_id),
        .s_ready(a_s_ready)
    );

    axi_rr_arb #(.NM(3), .DW(DW)) u_dut_b (
        .clk(clk), .rst(rst),
        .m_data(b_m_data), .m_valid(b_m_valid), .m_last(b_m_last), .m_ready(b_m_ready),
        .s_data(b_s_data), .s_valid(b_s_valid), .s_last(b_s_last), .s_id(b_s_id),
        .s_ready(b_s_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int i, input logic [DW-1:0] d, input logic l);
        a_m_data[i*DW +: DW] = d;
        a_m_last[i]          = l;
    endtask

    task automatic beat_a(input string tag, input logic [DW-1:0] d, input logic l, input logic [1:0] id);
        check({tag, ".valid"}, a_s_valid, 1'b1);
        check({tag, ".data"},  a_s_data,  d);
        check({tag, ".last"},  a_s_last,  l);
        check({tag, ".id"},    a_s_id,    id);
    endtask

    // Soak bookkeeping
    localparam int SOAK_CYC  = 2000;
    localparam int DRAIN_CYC = 40;
    logic [DW-1:0] sb_q [3][$];
    int            beat_i [3];
    int            len_i  [3];
    int            pkt_i  [3];
    int            wait_cnt [3];
    int            owner;
    logic [2:0]    acc;
    logic          exp_v, nxt_v, exp_l, nxt_l;
    logic [DW-1:0] exp_d, nxt_d;
    logic [1:0]    exp_id, nxt_id;
    logic          draining;

    initial begin
        rst       = 1'b1;
        a_m_valid = 4'hF;
        a_m_last  = 4'hF;
        for (int i = 0; i < 4; i++) a_m_data[i*DW +: DW] = DW'(i);
        a_s_ready = 1'b1;
        b_m_valid = '0;
        b_m_last  = '0;
        b_m_data  = '0;
        b_s_ready = 1'b1;

        // Reset with every requester valid
        repeat (3) begin
            tick();
            check("rst_s_valid", a_s_valid, 1'b0);
            check("rst_m_ready", a_m_ready, 4'b0000);
        end
        rst = 1'b0;
        #1;
        check("first_grant", a_m_ready, 4'b0001);

        // Single-beat packets from everyone: strict rotation, one beat per cycle
        for (int k = 1; k <= 8; k++) begin
            tick();
            beat_a("rr", DW'((k - 1) % 4), 1'b1, 2'((k - 1) % 4));
            check("rr_ready", a_m_ready, 4'b0001 << (k % 4));
        end

        // Requester 1 three-beat packet, requester 2 waiting throughout
        a_m_valid = 4'b0110;
        set_a(1, 16'h00A0, 1'b0);
        set_a(2, 16'h00B2, 1'b1);
        #1;
        check("lock_grant", a_m_ready, 4'b0010);
        tick();
        beat_a("lock0", 16'h00A0, 1'b0, 2'd1);
        set_a(1, 16'h00A1, 1'b0);
        #1;
        check("lock_excl0", a_m_ready, 4'b0010);
        tick();
        beat_a("lock1", 16'h00A1, 1'b0, 2'd1);
        set_a(1, 16'h00A2, 1'b1);
        #1;
        check("lock_excl1", a_m_ready, 4'b0010);
        tick();
        beat_a("lock2", 16'h00A2, 1'b1, 2'd1);
        a_m_valid = 4'b0100;
        #1;
        check("switch_grant", a_m_ready, 4'b0100);
        tick();
        beat_a("switch", 16'h00B2, 1'b1, 2'd2);

        // Backpressure for 5 cycles inside requester 0's packet
        a_m_valid = 4'b0001;
        set_a(0, 16'h00C0, 1'b0);
        #1;
        check("bp_grant", a_m_ready, 4'b0001);
        tick();
        beat_a("bp0", 16'h00C0, 1'b0, 2'd0);
        set_a(0, 16'h00C1, 1'b0);
        a_s_ready = 1'b0;
        #1;
        check("bp_stall_ready", a_m_ready, 4'b0000);
        repeat (5) begin
            tick();
            beat_a("bp_hold", 16'h00C0, 1'b0, 2'd0);
            check("bp_hold_ready", a_m_ready, 4'b0000);
        end
        a_s_ready = 1'b1;
        #1;
        check("bp_release", a_m_ready, 4'b0001);
        tick();
        beat_a("bp1", 16'h00C1, 1'b0, 2'd0);
        set_a(0, 16'h00C2, 1'b0);
        tick();
        beat_a("bp2", 16'h00C2, 1'b0, 2'd0);
        set_a(0, 16'h00C3, 1'b1);
        tick();
        beat_a("bp3", 16'h00C3, 1'b1, 2'd0);
        a_m_valid = 4'b0000;
        tick();
        check("drain_s_valid", a_s_valid, 1'b0);

        // Requester 3 pauses mid-packet while requester 0 is valid; then reset
        a_m_valid = 4'b1001;
        set_a(3, 16'h00D0, 1'b0);
        set_a(0, 16'h00E0, 1'b1);
        #1;
        check("gap_grant", a_m_ready, 4'b1000);
        tick();
        beat_a("gap0", 16'h00D0, 1'b0, 2'd3);
        a_m_valid = 4'b0001;
        #1;
        check("gap_ready", a_m_ready, 4'b1000);
        repeat (2) begin
            tick();
            check("gap_s_valid", a_s_valid, 1'b0);
            check("gap_hold", a_m_ready, 4'b1000);
        end
        a_m_valid = 4'b1001;
        set_a(3, 16'h00D1, 1'b0);
        tick();
        beat_a("gap1", 16'h00D1, 1'b0, 2'd3);
        set_a(3, 16'h00D2, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_ready", a_m_ready, 4'b0000);
        tick();
        check("rst_mid_s_valid", a_s_valid, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_ptr0", a_m_ready, 4'b0001);
        tick();
        beat_a("post_rst", 16'h00E0, 1'b1, 2'd0);
        a_m_valid = 4'b0000;

        // Random soak on the NM=3 instance
        owner = -1;
        exp_v = 1'b0;
        exp_d = '0;
        exp_l = 1'b0;
        exp_id = '0;
        for (int i = 0; i < 3; i++) begin
            beat_i[i]   = 0;
            pkt_i[i]    = 0;
            len_i[i]    = $urandom_range(1, 3);
            wait_cnt[i] = 0;
        end
        for (int c = 0; c < SOAK_CYC + DRAIN_CYC; c++) begin
            draining = (c >= SOAK_CYC);
            for (int i = 0; i < 3; i++) begin
                if (!b_m_valid[i] && (draining ? (beat_i[i] != 0) : ($urandom_range(0, 3) != 0))) begin
                    b_m_valid[i]          = 1'b1;
                    b_m_data[i*DW +: DW]  = {2'(i), 8'(pkt_i[i]), 6'(beat_i[i])};
                    b_m_last[i]           = (beat_i[i] == len_i[i] - 1);
                end
            end
            b_s_ready = draining ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;

            check("soak_s_valid", b_s_valid, exp_v);
            if (exp_v) begin
                check("soak_s_data", b_s_data, exp_d);
                check("soak_s_id",   b_s_id,   exp_id);
                check("soak_s_last", b_s_last, exp_l);
            end
            check("soak_onehot", $countones(b_m_ready) <= 1, 1'b1);

            if (b_s_valid && b_s_ready) begin
                check("soak_id_range", b_s_id < 2'd3, 1'b1);
                if (b_s_id < 2'd3) begin
                    check("soak_sb_nonempty", sb_q[b_s_id].size() != 0, 1'b1);
                    if (sb_q[b_s_id].size() != 0) check("soak_order", b_s_data, sb_q[b_s_id].pop_front());
                end
            end

            acc   = b_m_valid & b_m_ready;
            nxt_v = b_s_ready ? 1'b0 : exp_v;
            nxt_d = exp_d;
            nxt_l = exp_l;
            nxt_id = exp_id;
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) begin
                    if (owner >= 0) begin
                        check("soak_interleave", i, owner);
                    end else begin
                        for (int j = 0; j < 3; j++) begin
                            if (j != i && b_m_valid[j]) begin
                                wait_cnt[j]++;
                                check("soak_fair", wait_cnt[j] <= 2, 1'b1);
                            end
                        end
                        wait_cnt[i] = 0;
                    end
                    sb_q[i].push_back(b_m_data[i*DW +: DW]);
                    owner  = b_m_last[i] ? -1 : i;
                    nxt_v  = 1'b1;
                    nxt_d  = b_m_data[i*DW +: DW];
                    nxt_l  = b_m_last[i];
                    nxt_id = 2'(i);
                    if (b_m_last[i]) begin
                        pkt_i[i]++;
                        beat_i[i] = 0;
                        len_i[i]  = $urandom_range(1, 3);
                    end else begin
                        beat_i[i]++;
                    end
                end
            end
            exp_v  = nxt_v;
            exp_d  = nxt_d;
            exp_l  = nxt_l;
            exp_id = nxt_id;

            @(posedge clk);
            #1;
            b_m_valid = b_m_valid & ~acc;
        end
        for (int i = 0; i < 3; i++) check("soak_drained", sb_q[i].size(), 0);
        check("soak_owner_free", owner, -1);
        check("soak_final_valid", b_s_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
